// File: rtl/proc_pkg.sv
// proc_pkg: shared widths and types for the ALU writeback slice.
//   DW / RA           : datapath width and register-file address width
//   alu_wb_t          : bundle handed from the ALU to the writeback stage
//   flag_t            : architectural shift-carry / parity flag pair
//   next_flags()      : flag update rule (clear has priority over load)
package proc_pkg;

  localparam int DW = 8;
  localparam int RA = 3;

  typedef struct packed {
    logic [DW-1:0] rslt;
    logic          sc_o;
    logic          sc_en;
    logic          sc_clr;
    logic          pari;
    logic          pari_clr;
    logic          wr_en;
    logic [RA-1:0] wr_addr;
  } alu_wb_t;

  typedef struct packed {
    logic sc;
    logic pari;
  } flag_t;

  // Next value of the flag pair for an accepted instruction.
  function automatic flag_t next_flags(input flag_t cur,
                                       input logic  sc_o,
                                       input logic  sc_en,
                                       input logic  sc_clr,
                                       input logic  pari,
                                       input logic  pari_clr);
    flag_t n;
    n = cur;
    if (sc_clr) begin
      n.sc = 1'b0;
    end else if (sc_en) begin
      n.sc = sc_o;
    end else begin
      n.sc = cur.sc;
    end
    if (pari_clr) begin
      n.pari = 1'b0;
    end else begin
      n.pari = pari;
    end
    return n;
  endfunction

endpackage

// File: rtl/flag_regs.sv
// flag_regs: architectural shift-carry and parity flags read back by the ALU.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset (flags -> 0)
//   i_en         : instruction accepted this cycle; flags update only then
//   i_sc_o/i_sc_en/i_sc_clr     : shift-carry load value, load enable, clear
//   i_pari/i_pari_clr           : parity result, clear select
//   o_flags      : current flag pair
module flag_regs
  import proc_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  i_en,
  input  logic  i_sc_o,
  input  logic  i_sc_en,
  input  logic  i_sc_clr,
  input  logic  i_pari,
  input  logic  i_pari_clr,
  output flag_t o_flags
);

  flag_t r_flags;

  // Flags change only for an accepted instruction; stalls and flushes hold them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flags <= '0;
    end else if (i_en) begin
      r_flags <= next_flags(r_flags, i_sc_o, i_sc_en, i_sc_clr, i_pari, i_pari_clr);
    end
  end

  assign o_flags = r_flags;

endmodule

// File: rtl/alu_wb_stage.sv
// alu_wb_stage: single-entry pipeline register between the ALU and the
// register file, plus the ALU flag registers, forwarding tap and retire count.
// Ports:
//   clk, reset                    : clock, asynchronous active-high reset
//   in_valid / in_ready           : ALU-side handshake
//   alu_rslt, wr_en_in, wr_addr_in: captured instruction fields
//   alu_sc_o/_en/_clr, alu_pari/_clr : flag update controls
//   flush                         : drop the held entry, block accept
//   sc_q, pari_q                  : flags fed back to the ALU
//   out_valid / out_ready         : register-file-side handshake
//   rf_we, rf_waddr, rf_wdata     : register write port
//   fwd_valid, fwd_addr, fwd_data : forwarding tap of the held entry
//   retire_cnt                    : completed output handshakes (wraps)
module alu_wb_stage
  import proc_pkg::*;
#(
  parameter int DW = proc_pkg::DW,
  parameter int RA = proc_pkg::RA,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] alu_rslt,
  input  logic          alu_sc_o,
  input  logic          alu_sc_en,
  input  logic          alu_sc_clr,
  input  logic          alu_pari,
  input  logic          alu_pari_clr,
  input  logic          wr_en_in,
  input  logic [RA-1:0] wr_addr_in,
  input  logic          flush,
  output logic          sc_q,
  output logic          pari_q,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          rf_we,
  output logic [RA-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic          fwd_valid,
  output logic [RA-1:0] fwd_addr,
  output logic [DW-1:0] fwd_data,
  output logic [CW-1:0] retire_cnt
);

  alu_wb_t       w_bundle;
  flag_t         w_flags;
  logic          w_acc;
  logic          w_done;
  logic          w_retire;

  logic          r_valid;
  logic          r_wen;
  logic [RA-1:0] r_addr;
  logic [DW-1:0] r_data;
  logic [CW-1:0] r_cnt;

  // Gather the ALU-side inputs into one bundle.
  always_comb begin
    w_bundle          = '0;
    w_bundle.rslt     = alu_rslt;
    w_bundle.sc_o     = alu_sc_o;
    w_bundle.sc_en    = alu_sc_en;
    w_bundle.sc_clr   = alu_sc_clr;
    w_bundle.pari     = alu_pari;
    w_bundle.pari_clr = alu_pari_clr;
    w_bundle.wr_en    = wr_en_in;
    w_bundle.wr_addr  = wr_addr_in;
  end

  // Ready when the slot is empty or draining this cycle, so a continuous
  // stream flows without bubbles; flush blocks any new accept.
  assign in_ready = ~flush & (~r_valid | out_ready);
  assign w_acc    = in_valid & in_ready;
  assign w_done   = r_valid & out_ready;
  assign w_retire = w_done & ~flush;

  flag_regs u_flag_regs (
    .clk        (clk),
    .reset      (reset),
    .i_en       (w_acc),
    .i_sc_o     (w_bundle.sc_o),
    .i_sc_en    (w_bundle.sc_en),
    .i_sc_clr   (w_bundle.sc_clr),
    .i_pari     (w_bundle.pari),
    .i_pari_clr (w_bundle.pari_clr),
    .o_flags    (w_flags)
  );

  // Held entry: fields load on accept and otherwise stay put, so the write
  // port is stable during a stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_wen   <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      if (w_acc) begin
        r_wen  <= w_bundle.wr_en;
        r_addr <= w_bundle.wr_addr;
        r_data <= w_bundle.rslt;
      end
      if (flush) begin
        r_valid <= 1'b0;
      end else if (w_acc) begin
        r_valid <= 1'b1;
      end else if (w_done) begin
        r_valid <= 1'b0;
      end
    end
  end

  // Retired-instruction counter; wraps naturally at 2^CW.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_retire) begin
      r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  assign sc_q       = w_flags.sc;
  assign pari_q     = w_flags.pari;
  assign out_valid  = r_valid;
  assign rf_we      = r_valid & out_ready & r_wen & ~flush;
  assign rf_waddr   = r_addr;
  assign rf_wdata   = r_data;
  assign fwd_valid  = r_valid & r_wen & ~flush;
  assign fwd_addr   = r_addr;
  assign fwd_data   = r_data;
  assign retire_cnt = r_cnt;

endmodule
